pc_branch_ctrl: RTL
===================

// Module: pc_branch_ctrl
// PURPOSE
//  Program-counter / branch stage directly downstream of the ALU. Latches the ALU's
//  compare result (cmp_src) and carry-out (sc_o) into architectural flags.
//  Evaluates conditional branches against those flags and sequences the program counter
//  that addresses instruction ROM. Returns the latched carry to the ALU's sc_i.
// PARAMETERS
//  PC_W   10  program counter width; instruction ROM depth = 2**PC_W
//  LUT_W   5  branch-target LUT index width; LUT has 2**LUT_W entries of PC_W bits
// PORTS
//  clk         in   1      rising-edge clock
//  reset_n     in   1      synchronous active-low reset
//  start       in   1      leave IDLE/HALT, begin execution at PC 0
//  halt        in   1      decoded halt instruction retiring this cycle
//  cmp_wr      in   1      ALU compare retiring; latch cmp_src
//  cmp_src     in   2      ALU compare code: 00 eq, 01 bg, 10 bl, 11 bne
//  carry_wr    in   1      ALU arithmetic retiring; latch sc_o
//  sc_o        in   1      ALU carry-out
//  branch_en   in   1      branch instruction retiring
//  br_cond     in   2      condition: 00 eq, 01 bg, 10 bl, 11 bne
//  br_rel      in   1      1: PC-relative (signed LUT entry); 0: absolute LUT entry
//  br_idx      in   LUT_W  target LUT index
//  lut_wr      in   1      LUT write strobe (honoured in IDLE only)
//  lut_addr    in   LUT_W  LUT write address
//  lut_data    in   PC_W   LUT write data
//  prog_ctr    out  PC_W   instruction address
//  sc_flag     out  1      latched carry, wired to ALU sc_i
//  taken       out  1      registered: previous cycle's branch was taken
//  done        out  1      high while in HALT
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): state=IDLE, prog_ctr=0, sc_flag=0, taken=0, done=0,
//   cmp_valid=0, cmp_flag=00. LUT contents are NOT reset. Reset mid-run aborts at once.
//  FSM IDLE -> RUN on start. RUN -> HALT on halt. HALT -> RUN on start (prog_ctr<=0,
//   flags cleared as at reset). start in RUN ignored. lut_wr outside IDLE ignored.
//  IDLE: prog_ctr holds 0. HALT: prog_ctr frozen at halt address; done=1.
//  RUN next-PC priority: halt (hold PC) > taken branch > prog_ctr+1 (wraps 2**PC_W-1 -> 0).
//  Taken: branch_en & cmp_valid & cond; eq: flag==00, bg: ==01, bl: ==10, bne: !=00.
//   No compare since reset/start (cmp_valid=0) -> never taken; PC+1.
//  Target: absolute = lut[br_idx]; relative = prog_ctr + lut[br_idx] (2's complement
//   PC_W bits, result modulo 2**PC_W, no saturation).
//  Flags update on the edge after cmp_wr/carry_wr, in RUN only; a branch in the same
//   cycle as cmp_wr evaluates the OLD flag. cmp_wr sets cmp_valid=1.
//  taken is registered 1 cycle, 0 outside RUN. Latency branch_en -> new prog_ctr: 1 clk.
// CONFIGURATION
//  BR_LINK_EN defined: adds ports link_en (in,1) and ret (in,1) plus a PC_W link register
//   (reset 0). Taken branch with link_en saves prog_ctr+1; ret in RUN loads prog_ctr
//   from link register (priority: halt > ret > branch > +1). Single-depth; nested
//   call overwrites. Undefined: ports and register absent, behaviour as above.
// STRUCTURE
//  proc_pkg: cond_t enum (COND_EQ/BG/BL/BNE = 00/01/10/11, shared with ALU cmp_src),
//   pcb_state_t enum {IDLE, RUN, HALT}, PC_W/LUT_W defaults.
//  Sub-module branch_lut: 2**LUT_W x PC_W register array, 1 write port, 1 async read port.
// TESTING
//  1 reset, start, 5 idle cycles -> prog_ctr 0,1,2,3,4,5; sc_flag=0; done=0.
//  2 lut[3]=40; cmp_wr cmp_src=01; then branch_en br_cond=01 br_rel=0 idx=3 -> PC=40
//    next clk, taken=1; same with br_cond=00 -> PC+1, taken=0.
//  3 lut[1]=10'h3FC (-4) at PC=2, eq flag, relative eq branch -> PC wraps to 1022.
//  4 branch before any compare (cmp_valid=0), br_cond=11 -> not taken; PC=1023 +1 -> 0.
//  5 cmp_wr with 00 and bne branch same cycle after prior flag 10 -> taken (old flag).
//  6 halt at PC=7 -> PC stays 7, done=1; lut_wr ignored; start -> PC=0, flags cleared;
//    reset_n low mid-RUN -> IDLE, PC=0 next clk; BR_LINK_EN build: call/ret returns to PC+1.

Source files
------------

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared condition codes, PC/branch FSM states and width defaults
package proc_pkg;

    localparam int PC_W_DEFAULT  = 10;
    localparam int LUT_W_DEFAULT = 5;

    // Same encoding as the ALU compare result, so cmp_src latches straight into the flag.
    typedef enum logic [1:0] {
        COND_EQ  = 2'b00,
        COND_BG  = 2'b01,
        COND_BL  = 2'b10,
        COND_BNE = 2'b11
    } cond_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } pcb_state_t;

    function automatic logic cond_met(input cond_t cond, input logic [1:0] flag);
        logic met;
        case (cond)
            COND_EQ:  met = (flag == 2'b00);
            COND_BG:  met = (flag == 2'b01);
            COND_BL:  met = (flag == 2'b10);
            default:  met = (flag != 2'b00);
        endcase
        return met;
    endfunction

endpackage

// File: rtl/branch_lut.sv
// rtl/branch_lut.sv - branch-target table, one write port and one asynchronous read port
module branch_lut #(
    parameter int PC_W  = 10,
    parameter int LUT_W = 5
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [LUT_W-1:0] waddr_i,
    input  logic [PC_W-1:0]  wdata_i,
    input  logic [LUT_W-1:0] raddr_i,
    output logic [PC_W-1:0]  rdata_o
);

    // Contents deliberately survive reset; software loads the table while idle.
    logic [PC_W-1:0] mem_q [2**LUT_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pc_branch_ctrl.sv
// rtl/pc_branch_ctrl.sv - program counter / branch stage after the ALU; BR_LINK_EN adds call/return link register
module pc_branch_ctrl
    import proc_pkg::*;
#(
    parameter int PC_W  = PC_W_DEFAULT,
    parameter int LUT_W = LUT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             halt,
    input  logic             cmp_wr,
    input  logic [1:0]       cmp_src,
    input  logic             carry_wr,
    input  logic             sc_o,
    input  logic             branch_en,
    input  logic [1:0]       br_cond,
    input  logic             br_rel,
    input  logic [LUT_W-1:0] br_idx,
    input  logic             lut_wr,
    input  logic [LUT_W-1:0] lut_addr,
    input  logic [PC_W-1:0]  lut_data,
`ifdef BR_LINK_EN
    input  logic             link_en,
    input  logic             ret,
`endif
    output logic [PC_W-1:0]  prog_ctr,
    output logic             sc_flag,
    output logic             taken,
    output logic             done
);

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    pcb_state_t      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            sc_q, sc_d;
    logic            taken_q, taken_d;
    logic            cmp_valid_q, cmp_valid_d;
    logic [1:0]      cmp_flag_q, cmp_flag_d;
    logic            lut_we;
    logic [PC_W-1:0] lut_rdata;
    logic [PC_W-1:0] br_target;
    logic            br_hit;
    logic            ret_req;
    logic            link_req;
    logic [PC_W-1:0] link_q, link_d;

    branch_lut #(
        .PC_W  (PC_W),
        .LUT_W (LUT_W)
    ) u_lut (
        .clk     (clk),
        .we_i    (lut_we),
        .waddr_i (lut_addr),
        .wdata_i (lut_data),
        .raddr_i (br_idx),
        .rdata_o (lut_rdata)
    );

`ifdef BR_LINK_EN
    assign ret_req  = ret;
    assign link_req = link_en;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            link_q <= '0;
        end else begin
            link_q <= link_d;
        end
    end
`else
    assign ret_req  = 1'b0;
    assign link_req = 1'b0;
    assign link_q   = '0;
`endif

    // Relative targets are plain modulo-2**PC_W adds: the LUT entry is two's complement.
    assign br_target = br_rel ? (pc_q + lut_rdata) : lut_rdata;
    assign br_hit    = branch_en & cmp_valid_q & cond_met(cond_t'(br_cond), cmp_flag_q);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        sc_d        = sc_q;
        taken_d     = 1'b0;
        cmp_valid_d = cmp_valid_q;
        cmp_flag_d  = cmp_flag_q;
        link_d      = link_q;
        lut_we      = 1'b0;
        case (state_q)
            IDLE, HALT: begin
                lut_we = lut_wr && (state_q == IDLE);
                if (start) begin
                    state_d     = RUN;
                    pc_d        = '0;
                    sc_d        = 1'b0;
                    cmp_valid_d = 1'b0;
                    cmp_flag_d  = 2'b00;
                end
            end
            RUN: begin
                // Branch evaluation above uses the pre-update flags.
                if (cmp_wr) begin
                    cmp_flag_d  = cmp_src;
                    cmp_valid_d = 1'b1;
                end
                if (carry_wr) begin
                    sc_d = sc_o;
                end
                if (halt) begin
                    state_d = HALT;
                end else if (ret_req) begin
                    pc_d = link_q;
                end else if (br_hit) begin
                    pc_d    = br_target;
                    taken_d = 1'b1;
                    if (link_req) begin
                        link_d = pc_q + PC_ONE;
                    end
                end else begin
                    pc_d = pc_q + PC_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            sc_q        <= 1'b0;
            taken_q     <= 1'b0;
            cmp_valid_q <= 1'b0;
            cmp_flag_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            sc_q        <= sc_d;
            taken_q     <= taken_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_flag_q  <= cmp_flag_d;
        end
    end

    assign prog_ctr = pc_q;
    assign sc_flag  = sc_q;
    assign taken    = taken_q;
    assign done     = (state_q == HALT);

endmodule
